// File: rtl/mat_pkg.sv
// Shared types and default widths for the matrix address generator.
package mat_pkg;

  localparam int ADDR_W = 8;
  localparam int DIM_W  = 4;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    READY = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mat_addr_gen_if.sv
// Control-unit side bundle: configuration, strobes and address outputs.
interface mat_addr_gen_if
  import mat_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DIM_W
);

  logic          cfg_load;
  logic [DW-1:0] cfg_rows;
  logic [DW-1:0] cfg_cols;
  logic [AW-1:0] cfg_base;
  logic          mar_inc;
  logic          col_inc;
  logic          row_inc;
  logic          col_zero;
  logic          dmem_read;
  logic          dmem_write;
  logic [AW-1:0] mar;
  logic [DW-1:0] row;
  logic [DW-1:0] col;
  logic [AW-1:0] elem_addr;
  logic          col_wrap;
  logic          ready;
  logic          done;
  logic          err;

  modport master (
    output cfg_load, cfg_rows, cfg_cols, cfg_base,
    output mar_inc, col_inc, row_inc, col_zero,
    output dmem_read, dmem_write,
    input  mar, row, col, elem_addr,
    input  col_wrap, ready, done, err
  );

  modport slave (
    input  cfg_load, cfg_rows, cfg_cols, cfg_base,
    input  mar_inc, col_inc, row_inc, col_zero,
    input  dmem_read, dmem_write,
    output mar, row, col, elem_addr,
    output col_wrap, ready, done, err
  );

endinterface

// File: rtl/edge_det.sv
// Rising-edge detector against a registered previous value.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/mat_addr_gen.sv
// Matrix address generator: turns control strobes into mar/row/col
// and a linear element address, with done and sticky error status.
module mat_addr_gen
  import mat_pkg::*;
#(
  parameter int ADDR_W = mat_pkg::ADDR_W,
  parameter int DIM_W  = mat_pkg::DIM_W
) (
  input logic           clk,
  input logic           reset,
  mat_addr_gen_if.slave bus
);

  state_t             state;
  logic [DIM_W-1:0]   rows;
  logic [DIM_W-1:0]   cols;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  row_base;
  logic [ADDR_W-1:0]  mar;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;
  logic               col_wrap;
  logic               err;
  logic               mar_e;
  logic               col_e;
  logic               row_e;
  logic               zero_e;
  logic               conflict;

  edge_det u_mar  (.clk(clk), .reset(reset),
                   .d(bus.mar_inc),  .rise(mar_e));
  edge_det u_col  (.clk(clk), .reset(reset),
                   .d(bus.col_inc),  .rise(col_e));
  edge_det u_row  (.clk(clk), .reset(reset),
                   .d(bus.row_inc),  .rise(row_e));
  edge_det u_zero (.clk(clk), .reset(reset),
                   .d(bus.col_zero), .rise(zero_e));

  assign conflict = bus.dmem_read & bus.dmem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNCFG;
      rows     <= '0;
      cols     <= '0;
      base     <= '0;
      row_base <= '0;
      mar      <= '0;
      row      <= '0;
      col      <= '0;
      col_wrap <= 1'b0;
      err      <= 1'b0;
    end else begin
      col_wrap <= 1'b0;
      if (conflict) err <= 1'b1;
      if (bus.cfg_load) begin
        // cfg_load swallows any strobe edge of this cycle
        if (bus.cfg_rows != '0 && bus.cfg_cols != '0) begin
          rows     <= bus.cfg_rows;
          cols     <= bus.cfg_cols;
          base     <= bus.cfg_base;
          mar      <= bus.cfg_base;
          row      <= '0;
          col      <= '0;
          row_base <= '0;
          state    <= READY;
          err      <= conflict;
        end else begin
          err   <= 1'b1;
          state <= UNCFG;
        end
      end else if (state == READY) begin
        if (mar_e) mar <= mar + 1'b1;
        if (zero_e) begin
          col <= '0;
        end else if (col_e) begin
          if (col == cols - 1'b1) begin
            col      <= '0;
            col_wrap <= 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if (row_e) begin
          if (row == rows - 1'b1) begin
            row      <= '0;
            row_base <= '0;
            state    <= DONE;
          end else begin
            row      <= row + 1'b1;
            row_base <= row_base + ADDR_W'(cols);
          end
        end
      end
    end
  end

  assign bus.mar       = mar;
  assign bus.row       = row;
  assign bus.col       = col;
  assign bus.elem_addr = base + row_base + ADDR_W'(col);
  assign bus.col_wrap  = col_wrap;
  assign bus.ready     = (state == READY);
  assign bus.done      = (state == DONE);
  assign bus.err       = err;

endmodule

// File: tb/tb_mat_addr_gen.sv
// Directed bench for mat_addr_gen with hand-computed expectations.
module tb_mat_addr_gen;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mat_addr_gen_if bus ();

  mat_addr_gen dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.cfg_load   = 1'b0;
    bus.cfg_rows   = '0;
    bus.cfg_cols   = '0;
    bus.cfg_base   = '0;
    bus.mar_inc    = 1'b0;
    bus.col_inc    = 1'b0;
    bus.row_inc    = 1'b0;
    bus.col_zero   = 1'b0;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_mar", 32'(bus.mar), 32'h0);
    chk("rst_row", 32'(bus.row), 32'h0);
    chk("rst_col", 32'(bus.col), 32'h0);
    chk("rst_elem", 32'(bus.elem_addr), 32'h0);
    chk("rst_wrap", 32'(bus.col_wrap), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);

    bus.cfg_rows = 4'd2;
    bus.cfg_cols = 4'd3;
    bus.cfg_base = 8'h40;
    bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    chk("cfg_ready", 32'(bus.ready), 32'h1);
    chk("cfg_mar", 32'(bus.mar), 32'h40);
    chk("cfg_elem", 32'(bus.elem_addr), 32'h40);

    bus.col_inc = 1'b1; tick();
    bus.col_inc = 1'b0; tick();
    bus.col_inc = 1'b1; tick();
    bus.col_inc = 1'b0; tick();
    chk("col2", 32'(bus.col), 32'h2);
    chk("elem42", 32'(bus.elem_addr), 32'h42);

    bus.row_inc  = 1'b1;
    bus.col_zero = 1'b1;
    tick();
    chk("adv_row", 32'(bus.row), 32'h1);
    chk("adv_col", 32'(bus.col), 32'h0);
    chk("adv_elem", 32'(bus.elem_addr), 32'h43);
    chk("adv_wrap", 32'(bus.col_wrap), 32'h0);
    bus.row_inc  = 1'b0;
    bus.col_zero = 1'b0;
    tick();

    bus.col_inc = 1'b1;
    tick(); tick(); tick();
    chk("held_col", 32'(bus.col), 32'h1);
    bus.col_inc = 1'b0; tick();

    bus.col_zero = 1'b1; tick();
    bus.col_zero = 1'b0; tick();
    chk("zero_col", 32'(bus.col), 32'h0);
    bus.col_inc = 1'b1; tick();
    bus.col_inc = 1'b0; tick();
    bus.col_inc = 1'b1; tick();
    bus.col_inc = 1'b0; tick();
    chk("pre_wrap", 32'(bus.col), 32'h2);
    chk("pre_wrap_pulse", 32'(bus.col_wrap), 32'h0);
    bus.col_inc = 1'b1; tick();
    chk("wrap_col", 32'(bus.col), 32'h0);
    chk("wrap_pulse", 32'(bus.col_wrap), 32'h1);
    chk("wrap_elem", 32'(bus.elem_addr), 32'h43);
    bus.col_inc = 1'b0; tick();
    chk("wrap_pulse_end", 32'(bus.col_wrap), 32'h0);

    bus.row_inc = 1'b1; tick();
    chk("done", 32'(bus.done), 32'h1);
    chk("done_ready", 32'(bus.ready), 32'h0);
    chk("done_row", 32'(bus.row), 32'h0);
    chk("done_elem", 32'(bus.elem_addr), 32'h40);
    bus.row_inc = 1'b0; tick();
    bus.col_inc = 1'b1;
    bus.mar_inc = 1'b1; tick();
    bus.col_inc = 1'b0;
    bus.mar_inc = 1'b0; tick();
    chk("done_col_ign", 32'(bus.col), 32'h0);
    chk("done_mar_ign", 32'(bus.mar), 32'h40);
    chk("done_stays", 32'(bus.done), 32'h1);

    bus.dmem_read  = 1'b1;
    bus.dmem_write = 1'b1;
    tick();
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    chk("err_set", 32'(bus.err), 32'h1);
    tick();
    chk("err_sticky", 32'(bus.err), 32'h1);

    bus.cfg_cols = 4'd0;
    bus.cfg_load = 1'b1; tick();
    bus.cfg_load = 1'b0;
    chk("bad_err", 32'(bus.err), 32'h1);
    chk("bad_ready", 32'(bus.ready), 32'h0);
    chk("bad_done", 32'(bus.done), 32'h0);

    bus.cfg_rows = 4'd1;
    bus.cfg_cols = 4'd1;
    bus.cfg_base = 8'hFF;
    bus.cfg_load = 1'b1; tick();
    bus.cfg_load = 1'b0;
    chk("ok_err", 32'(bus.err), 32'h0);
    chk("ok_ready", 32'(bus.ready), 32'h1);
    chk("ok_mar", 32'(bus.mar), 32'hFF);
    chk("ok_elem", 32'(bus.elem_addr), 32'hFF);

    bus.mar_inc = 1'b1; tick();
    bus.mar_inc = 1'b0;
    chk("mar_wrap", 32'(bus.mar), 32'h00);
    tick();
    bus.mar_inc = 1'b1; tick();
    bus.mar_inc = 1'b0;
    chk("mar_01", 32'(bus.mar), 32'h01);
    tick();

    bus.mar_inc = 1'b1;
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("mid_rst_mar", 32'(bus.mar), 32'h0);
    chk("mid_rst_elem", 32'(bus.elem_addr), 32'h0);
    chk("mid_rst_ready", 32'(bus.ready), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    tick();
    chk("uncfg_mar_ign", 32'(bus.mar), 32'h0);
    bus.mar_inc = 1'b0;
    bus.col_inc = 1'b1; tick();
    bus.col_inc = 1'b0; tick();
    chk("uncfg_col_ign", 32'(bus.col), 32'h0);
    chk("uncfg_ready", 32'(bus.ready), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
